// File: rtl/quad_pkg.sv
// quad_pkg: shared definitions for the quadrature decoder.
//   state_t      - decoder FSM states (INIT, TRACK)
//   FILT_LEN_DEF - default glitch-filter length in clk edges
//   STEP_UP/DOWN - Gray position deltas identifying a legal step direction
//   gray_pos()   - maps the {A,B} Gray phase to a 0..3 position
package quad_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        TRACK = 1'b1
    } state_t;

    localparam int unsigned FILT_LEN_DEF = 3;

    // Difference (new - old, modulo 4) between Gray positions.
    // A delta of 2 means both phases toggled together: an illegal jump.
    localparam logic [1:0] STEP_UP   = 2'd1;
    localparam logic [1:0] STEP_DOWN = 2'd3;

    // 00 -> 0, 01 -> 1, 11 -> 2, 10 -> 3 (Gray to binary)
    function automatic logic [1:0] gray_pos(input logic [1:0] ab);
        return {ab[1], ab[1] ^ ab[0]};
    endfunction

endpackage

// File: rtl/sync_filter.sv
// sync_filter: 2-flop synchronizer followed by a stability filter for one
// encoder channel.
//   clk      - clock
//   reset_n  - asynchronous active-low reset
//   din      - raw asynchronous channel input
//   sync_out - synchronized (2nd flop) value
//   filt_out - filtered value; follows sync_out only after it has differed
//              for FILT_LEN consecutive edges
module sync_filter
    import quad_pkg::*;
#(
    parameter int unsigned FILT_LEN = FILT_LEN_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic sync_out,
    output logic filt_out
);

    localparam int unsigned CW = $clog2(FILT_LEN + 1);

    logic          s1;
    logic          s2;
    logic          filt;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            filt <= 1'b0;
            cnt  <= '0;
        end else begin
            s1 <= din;
            s2 <= s1;
            if (s2 == filt) begin
                cnt <= '0;
            end else if (cnt == CW'(FILT_LEN - 1)) begin
                // This edge is the FILT_LEN-th consecutive differing one.
                filt <= s2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign sync_out = s2;
    assign filt_out = filt;

endmodule

// File: rtl/quadrature_decoder.sv
// quadrature_decoder: converts filtered encoder phases A/B into counter
// enable/direction strobes.
//   clk       - clock
//   reset_n   - asynchronous active-low reset
//   a_in/b_in - raw encoder phases (asynchronous)
//   clear_err - synchronous clear of the sticky error flag
//   enable    - one-cycle pulse per valid quadrature step
//   up        - direction of the most recent valid step (1 = up)
//   err       - sticky flag for an illegal double-phase transition
//   phase     - accepted filtered {A,B}
module quadrature_decoder
    import quad_pkg::*;
#(
    parameter int unsigned FILT_LEN = FILT_LEN_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       a_in,
    input  logic       b_in,
    input  logic       clear_err,
    output logic       enable,
    output logic       up,
    output logic       err,
    output logic [1:0] phase
);

    localparam int unsigned CW = $clog2(FILT_LEN + 1);

    logic          sync_a, sync_b, filt_a, filt_b;
    logic [1:0]    sync_ab, filt_ab;

    state_t        state, state_nxt;
    logic [1:0]    phase_d;
    logic [1:0]    cand, cand_d;
    logic [CW-1:0] init_cnt, init_cnt_d, cnt_eff;
    logic [1:0]    delta;
    logic          enable_d, up_d, err_d;

    sync_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
        .clk      (clk),
        .reset_n  (reset_n),
        .din      (a_in),
        .sync_out (sync_a),
        .filt_out (filt_a)
    );

    sync_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
        .clk      (clk),
        .reset_n  (reset_n),
        .din      (b_in),
        .sync_out (sync_b),
        .filt_out (filt_b)
    );

    assign sync_ab = {sync_a, sync_b};
    assign filt_ab = {filt_a, filt_b};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= INIT;
            phase    <= 2'b00;
            cand     <= 2'b00;
            init_cnt <= '0;
            enable   <= 1'b0;
            up       <= 1'b1;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            phase    <= phase_d;
            cand     <= cand_d;
            init_cnt <= init_cnt_d;
            enable   <= enable_d;
            up       <= up_d;
            err      <= err_d;
        end
    end

    always_comb begin
        state_nxt  = state;
        phase_d    = phase;
        cand_d     = cand;
        init_cnt_d = init_cnt;
        cnt_eff    = '0;
        delta      = '0;
        enable_d   = 1'b0;
        up_d       = up;
        err_d      = err & ~clear_err;

        case (state)
            INIT: begin
                // Count consecutive edges with an unchanged synchronized pair;
                // an edge that sees a new value restarts the count at 1.
                cnt_eff = (sync_ab == cand) ? init_cnt : '0;
                if (cnt_eff == CW'(FILT_LEN - 1)) begin
                    phase_d    = sync_ab;
                    init_cnt_d = '0;
                    state_nxt  = TRACK;
                end else begin
                    cand_d     = sync_ab;
                    init_cnt_d = cnt_eff + CW'(1);
                end
            end
            TRACK: begin
                // A change arriving while enable is high is held one cycle so
                // that two steps never produce back-to-back pulses.
                if (filt_ab != phase && !enable) begin
                    phase_d = filt_ab;
                    delta   = gray_pos(filt_ab) - gray_pos(phase);
                    if (delta == STEP_UP) begin
                        enable_d = 1'b1;
                        up_d     = 1'b1;
                    end else if (delta == STEP_DOWN) begin
                        enable_d = 1'b1;
                        up_d     = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_nxt = INIT;
        endcase
    end

endmodule

// File: tb/tb_quadrature_decoder.sv
// tb_quadrature_decoder: directed self-checking bench for quadrature_decoder
// with FILT_LEN = 3. Inputs are driven and outputs sampled on the falling
// edge of clk.
module tb_quadrature_decoder;
    import quad_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       a_in;
    logic       b_in;
    logic       clear_err;
    logic       enable;
    logic       up;
    logic       err;
    logic [1:0] phase;

    int         tests  = 0;
    int         failed = 0;
    logic [3:0] ctr;

    quadrature_decoder #(.FILT_LEN(3)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .a_in      (a_in),
        .b_in      (b_in),
        .clear_err (clear_err),
        .enable    (enable),
        .up        (up),
        .err       (err),
        .phase     (phase)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance ncyc falling edges, recording enable pulses and updating the
    // downstream 4-bit counter model.
    task automatic watch(input int ncyc, output int pulses, output int first_at,
                         output int max_run, output logic last_up);
        int run;
        pulses   = 0;
        first_at = -1;
        max_run  = 0;
        run      = 0;
        last_up  = up;
        for (int i = 1; i <= ncyc; i++) begin
            @(negedge clk);
            if (enable === 1'b1) begin
                run++;
                if (run > max_run) max_run = run;
                if (run == 1) begin
                    pulses++;
                    if (first_at < 0) first_at = i;
                end
                last_up = up;
                ctr = up ? ctr + 4'd1 : ctr - 4'd1;
            end else begin
                run = 0;
            end
        end
    endtask

    task automatic do_reset(input logic [1:0] ab);
        @(negedge clk);
        reset_n   = 1'b0;
        {a_in, b_in} = ab;
        clear_err = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    int         p, f, r, total;
    logic       lu;
    logic [1:0] seq_up [4];
    logic [1:0] seq_dn [4];

    initial begin
        seq_up = '{2'b01, 2'b11, 2'b10, 2'b00};
        seq_dn = '{2'b10, 2'b11, 2'b01, 2'b00};
        ctr       = 4'd0;
        reset_n   = 1'b1;
        a_in      = 1'b1;
        b_in      = 1'b1;
        clear_err = 1'b0;

        // Reset with A=B=1 held at power-up
        #2 reset_n = 1'b0;
        #1;
        check("rst_enable", 32'(enable), 32'd0);
        check("rst_up", 32'(up), 32'd1);
        check("rst_err", 32'(err), 32'd0);
        check("rst_phase", 32'(phase), 32'd0);
        check("rst_state", 32'(dut.state), 32'(INIT));
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        watch(4, p, f, r, lu);
        check("init_phase_e4", 32'(phase), 32'd0);
        check("init_state_e4", 32'(dut.state), 32'(INIT));
        watch(1, p, f, r, lu);
        check("init_phase_e5", 32'(phase), 32'd3);
        check("init_state_e5", 32'(dut.state), 32'(TRACK));
        watch(10, p, f, r, lu);
        check("init_no_enable", 32'(p), 32'd0);
        check("init_up", 32'(up), 32'd1);
        check("init_err", 32'(err), 32'd0);

        // Forward sequence from 00
        do_reset(2'b00);
        check("fwd_start_phase", 32'(phase), 32'd0);
        for (int i = 0; i < 4; i++) begin
            {a_in, b_in} = seq_up[i];
            watch(10, p, f, r, lu);
            check($sformatf("fwd%0d_pulses", i), 32'(p), 32'd1);
            check($sformatf("fwd%0d_latency", i), 32'(f), 32'd6);
            check($sformatf("fwd%0d_width", i), 32'(r), 32'd1);
            check($sformatf("fwd%0d_up", i), 32'(lu), 32'd1);
            check($sformatf("fwd%0d_phase", i), 32'(phase), 32'(seq_up[i]));
        end
        check("fwd_err", 32'(err), 32'd0);

        // Reverse sequence from 00 into a downstream counter at 0
        ctr   = 4'd0;
        total = 0;
        for (int i = 0; i < 4; i++) begin
            {a_in, b_in} = seq_dn[i];
            watch(10, p, f, r, lu);
            total += p;
            check($sformatf("rev%0d_up", i), 32'(lu), 32'd0);
            check($sformatf("rev%0d_latency", i), 32'(f), 32'd6);
        end
        check("rev_pulses", 32'(total), 32'd4);
        check("rev_counter", 32'(ctr), 32'd12);
        check("rev_up_hold", 32'(up), 32'd0);
        check("rev_phase", 32'(phase), 32'd0);

        // 2-cycle glitch on A from phase 01
        {a_in, b_in} = 2'b01;
        watch(10, p, f, r, lu);
        check("gl_setup_phase", 32'(phase), 32'd1);
        a_in = 1'b1;
        watch(2, p, f, r, lu);
        total = p;
        a_in = 1'b0;
        watch(12, p, f, r, lu);
        total += p;
        check("gl_no_enable", 32'(total), 32'd0);
        check("gl_phase", 32'(phase), 32'd1);
        check("gl_err", 32'(err), 32'd0);

        // Illegal double-phase jumps and sticky error clear
        {a_in, b_in} = 2'b00;
        watch(10, p, f, r, lu);
        check("jmp_setup_phase", 32'(phase), 32'd0);
        check("jmp_setup_up", 32'(up), 32'd0);
        {a_in, b_in} = 2'b11;
        watch(12, p, f, r, lu);
        check("jmp_no_enable", 32'(p), 32'd0);
        check("jmp_phase", 32'(phase), 32'd3);
        check("jmp_err_set", 32'(err), 32'd1);
        check("jmp_up_hold", 32'(up), 32'd0);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        check("clr_err", 32'(err), 32'd0);
        {a_in, b_in} = 2'b00;
        watch(5, p, f, r, lu);
        total = p;
        check("clr_race_pre", 32'(err), 32'd0);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        check("clr_race_err", 32'(err), 32'd1);
        watch(6, p, f, r, lu);
        total += p;
        check("clr_race_no_enable", 32'(total), 32'd0);
        check("clr_race_phase", 32'(phase), 32'd0);

        // Reset asserted two edges into a step's filter window
        {a_in, b_in} = 2'b01;
        watch(4, p, f, r, lu);
        total = p;
        reset_n = 1'b0;
        #1;
        check("mid_rst_enable", 32'(enable), 32'd0);
        check("mid_rst_up", 32'(up), 32'd1);
        check("mid_rst_err", 32'(err), 32'd0);
        check("mid_rst_phase", 32'(phase), 32'd0);
        check("mid_rst_state", 32'(dut.state), 32'(INIT));
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        watch(5, p, f, r, lu);
        total += p;
        check("mid_reacq_phase", 32'(phase), 32'd1);
        check("mid_reacq_state", 32'(dut.state), 32'(TRACK));
        watch(10, p, f, r, lu);
        total += p;
        check("mid_no_enable", 32'(total), 32'd0);
        check("mid_up", 32'(up), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/quadrature_decoder.md
QUADRATURE_DECODER -- requirements
Module: quadrature_decoder

Interface
REQ-001 The parameter FILT_LEN SHALL have a default of 3 and set the number of consecutive stable clock edges (legal range 1..15) a synchronized channel needs before it is accepted.
REQ-002 The port clk SHALL be an input, 1 bit wide, and be the single clock; all flops trigger on its rising edge.
REQ-003 The port reset_n SHALL be an input, 1 bit wide, and be the reset: asynchronous, active-low.
REQ-004 The port a_in SHALL be an input, 1 bit wide, carrying encoder phase A, asynchronous to clk.
REQ-005 The port b_in SHALL be an input, 1 bit wide, carrying encoder phase B, asynchronous to clk.
REQ-006 The port clear_err SHALL be an input, 1 bit wide, and synchronously clear the sticky error flag.
REQ-007 The port enable SHALL be an output, 1 bit wide, pulsing high for one clk cycle per valid quadrature step; it drives the counter's enable.
REQ-008 The port up SHALL be an output, 1 bit wide, giving the direction of the most recent valid step (1 = up); it drives the counter's up.
REQ-009 The port err SHALL be an output, 1 bit wide, as a sticky flag set by an illegal double-phase transition.
REQ-010 The port phase SHALL be an output, 2 bits wide, holding the accepted filtered {A,B} value, for debug.

Function
REQ-011 Each channel SHALL pass through a 2-flop synchronizer before any other logic.
REQ-012 Per channel, the filtered value SHALL update on the FILT_LEN-th consecutive clock edge at which the synchronized value differs from it; any edge where they match SHALL zero that channel's stability counter.
REQ-013 The FSM SHALL have states INIT and TRACK.
REQ-014 In INIT, once synchronized {A,B} has held constant for FILT_LEN consecutive edges, phase SHALL load that value and the FSM SHALL move to TRACK, with no enable pulse and up unchanged.
REQ-015 In TRACK, a filtered phase change following the sequence 00->01->11->10->00 SHALL assert enable for exactly the next cycle with up=1.
REQ-016 In TRACK, a filtered phase change following the reverse sequence 00->10->11->01->00 SHALL assert enable for exactly the next cycle with up=0.
REQ-017 A filtered change of both bits on the same edge (00<->11, 01<->10) SHALL produce no enable, leave up unchanged, update phase, and set err on the next edge.
REQ-018 Wrap-around transitions (10->00 up, 00->10 down) SHALL be treated identically to any other legal step.
REQ-019 Latency SHALL be exactly FILT_LEN+3 clk edges from the first edge that samples a new stable input level to enable going high (6 for FILT_LEN=3).
REQ-020 up SHALL change only on the same edge that raises enable and SHALL hold its value otherwise.
REQ-021 enable SHALL never be high for two consecutive cycles.
REQ-022 A pulse narrower than FILT_LEN synchronized cycles SHALL produce no phase change, no enable and no err.
REQ-023 When clear_err and a new error event occur on the same edge, err SHALL remain 1 (set wins).
REQ-024 enable, up and err SHALL be driven directly from flops (registered outputs).

Reset
REQ-025 When reset_n is low, the block SHALL immediately force: synchronizers 0, stability counters 0, filtered values 0, phase=00, FSM=INIT, enable=0, up=1, err=0.
REQ-026 Reset asserted mid-step SHALL abort any pending filter count, and no enable SHALL be produced for that step.
REQ-027 After reset_n deasserts, the block SHALL always pass through INIT, so the input level present at power-up never generates a step.

Structure
REQ-028 The shared package quad_pkg SHALL hold the FSM state encoding (INIT, TRACK), the FILT_LEN default, and the 2-bit Gray step-direction constants.
REQ-029 A sub-module sync_filter (2-flop synchronizer plus stability counter, parameter FILT_LEN) SHALL be instantiated once per channel.
REQ-030 The step-decode logic and FSM SHALL remain in quadrature_decoder.
REQ-031 The counter width in quadrature_decoder SHALL be $clog2(FILT_LEN+1).

Verification
REQ-032 The bench SHALL check: release reset with a=1,b=1 held -> phase=11 after 5 edges, FSM in TRACK, enable stays 0, up=1.
REQ-033 The bench SHALL check: from phase 00, drive 01,11,10,00, each held 10 cycles -> exactly 4 enable pulses, each 1 cycle wide, up=1, each 6 edges after its input change.
REQ-034 The bench SHALL check: from phase 00, drive 10,11,01,00 -> 4 pulses with up=0; a downstream 4-bit counter starting at 0 reads 12.
REQ-035 The bench SHALL check: from phase 01, a 2-cycle glitch on a_in -> no phase change, enable=0, err=0.
REQ-036 The bench SHALL check: from phase 00, set a_in and b_in simultaneously -> no enable, phase=11, err=1; then pulse clear_err -> err=0; clear_err coincident with another 11->00 jump -> err stays 1.
REQ-037 The bench SHALL check: assert reset_n low 2 cycles into a step's filter window -> outputs reset immediately, no enable for that step, INIT reacquires the current input level.
